// File: rtl/udp_box_table_rx.sv
// rtl/udp_box_table_rx.sv - UDP payload byte stream to double-buffered box table for the HDMI overlay
module udp_box_table_rx #(
    parameter int X_W     = 11,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 2,
    parameter int MAX_BOX = 8,
    localparam int IDX_W  = (MAX_BOX > 1) ? $clog2(MAX_BOX) : 1,
    localparam int CNT_W  = $clog2(MAX_BOX + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    input  logic             i_last,
    input  logic             i_vsync,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [X_W-1:0]   o_start_x,
    output logic [Y_W-1:0]   o_start_y,
    output logic [X_W-1:0]   o_end_x,
    output logic [Y_W-1:0]   o_end_y,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic [CNT_W-1:0] o_box_cnt,
    output logic             o_commit,
    output logic             o_err,
    output logic             o_ovf
);

    localparam int REC_BITS  = 2 * X_W + 2 * Y_W + 3 * COLOR_W;
    localparam int REC_BYTES = (REC_BITS + 7) / 8;
    localparam int SH_W      = REC_BYTES * 8;
    localparam int BC_W      = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
    localparam int SX_LSB    = REC_BITS - X_W;
    localparam int SY_LSB    = SX_LSB - Y_W;
    localparam int EX_LSB    = SY_LSB - X_W;
    localparam int EY_LSB    = EX_LSB - Y_W;
    localparam int REP       = (8 + COLOR_W - 1) / COLOR_W;
    localparam int REP_W     = REP * COLOR_W;

    typedef enum logic {S_IDLE, S_RECV} state_t;

    state_t              state, state_nx;
    logic [BC_W-1:0]     byte_cnt;
    logic [SH_W-1:0]     shift_q;
    logic [CNT_W-1:0]    sh_cnt;
    logic [CNT_W-1:0]    act_cnt;
    logic                ovf_flag;
    logic                pending;
    logic [REC_BITS-1:0] shadow [MAX_BOX];
    logic [REC_BITS-1:0] active [MAX_BOX];

    logic                first;
    logic [BC_W-1:0]     cur_byte;
    logic [CNT_W-1:0]    cur_cnt;
    logic                cur_ovf;
    logic [SH_W-1:0]     shift_nx;
    logic [REC_BITS-1:0] rec_nx;
    logic                rec_ok;
    logic                rec_done;
    logic                store_en;
    logic                ovf_set;
    logic                good_end;
    logic                bad_end;
    logic [REC_BITS-1:0] rd_rec;

    function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
        logic [REP_W-1:0] rep;
        for (int i = 0; i < REP; i++) begin
            rep[i*COLOR_W +: COLOR_W] = c;
        end
        return rep[REP_W-1 -: 8];
    endfunction

    // The first byte of a packet is handled as if per-packet state were already cleared.
    assign first    = (state == S_IDLE);
    assign cur_byte = first ? '0 : byte_cnt;
    assign cur_cnt  = first ? '0 : sh_cnt;
    assign cur_ovf  = first ? 1'b0 : ovf_flag;
    assign shift_nx = SH_W'({shift_q, i_data});
    assign rec_nx   = shift_nx[SH_W-1 -: REC_BITS];
    assign rec_ok   = (rec_nx[SX_LSB +: X_W] <= rec_nx[EX_LSB +: X_W]) &&
                      (rec_nx[SY_LSB +: Y_W] <= rec_nx[EY_LSB +: Y_W]);
    assign rd_rec   = active[i_rd_idx];
    assign o_box_cnt = act_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (i_valid) begin
            state_nx = i_last ? S_IDLE : S_RECV;
        end
    end

    always_comb begin
        rec_done = 1'b0;
        store_en = 1'b0;
        ovf_set  = 1'b0;
        good_end = 1'b0;
        bad_end  = 1'b0;
        if (i_valid) begin
            rec_done = (cur_byte == BC_W'(REC_BYTES - 1));
            if (rec_done && rec_ok) begin
                if (cur_cnt < CNT_W'(MAX_BOX)) begin
                    store_en = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            if (i_last) begin
                good_end = rec_done;
                bad_end  = !rec_done;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt  <= '0;
            shift_q   <= '0;
            sh_cnt    <= '0;
            act_cnt   <= '0;
            ovf_flag  <= 1'b0;
            pending   <= 1'b0;
            o_commit  <= 1'b0;
            o_err     <= 1'b0;
            o_ovf     <= 1'b0;
            o_start_x <= '0;
            o_start_y <= '0;
            o_end_x   <= '0;
            o_end_y   <= '0;
            o_r       <= '0;
            o_g       <= '0;
            o_b       <= '0;
            for (int i = 0; i < MAX_BOX; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            o_commit <= i_vsync && pending;
            o_err    <= bad_end;
            o_ovf    <= good_end && (cur_ovf || ovf_set);

            if (i_valid) begin
                shift_q  <= shift_nx;
                byte_cnt <= rec_done ? '0 : cur_byte + BC_W'(1);
                sh_cnt   <= cur_cnt + CNT_W'(store_en);
                ovf_flag <= cur_ovf || ovf_set;
                if (store_en) begin
                    shadow[cur_cnt[IDX_W-1:0]] <= rec_nx;
                end
            end

            // Commit uses the registered pending, so a good end coinciding with vsync waits a frame.
            if (i_vsync && pending) begin
                active  <= shadow;
                act_cnt <= sh_cnt;
            end

            if (good_end) begin
                pending <= 1'b1;
            end else if ((i_vsync && pending) || (i_valid && first)) begin
                pending <= 1'b0;
            end

            o_start_x <= rd_rec[SX_LSB +: X_W];
            o_start_y <= rd_rec[SY_LSB +: Y_W];
            o_end_x   <= rd_rec[EX_LSB +: X_W];
            o_end_y   <= rd_rec[EY_LSB +: Y_W];
            o_r       <= expand(rd_rec[2*COLOR_W +: COLOR_W]);
            o_g       <= expand(rd_rec[COLOR_W +: COLOR_W]);
            o_b       <= expand(rd_rec[0 +: COLOR_W]);
        end
    end

endmodule

// File: tb/tb_udp_box_table_rx.sv
// tb/tb_udp_box_table_rx.sv - randomized bench for udp_box_table_rx against a packet-level table model
module tb_udp_box_table_rx;

    localparam int MAX_BOX = 8;

    typedef struct packed {
        logic [10:0] sx;
        logic [9:0]  sy;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic [1:0]  r;
        logic [1:0]  g;
        logic [1:0]  b;
    } rec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_last = 1'b0;
    logic        i_vsync = 1'b0;
    logic [2:0]  i_rd_idx = 3'd0;
    logic [10:0] o_start_x;
    logic [9:0]  o_start_y;
    logic [10:0] o_end_x;
    logic [9:0]  o_end_y;
    logic [7:0]  o_r;
    logic [7:0]  o_g;
    logic [7:0]  o_b;
    logic [3:0]  o_box_cnt;
    logic        o_commit;
    logic        o_err;
    logic        o_ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    rec_t pkt[$];
    rec_t m_shadow[$];
    rec_t m_active[$];
    bit   m_pend = 1'b0;

    udp_box_table_rx dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
        .i_vsync(i_vsync), .i_rd_idx(i_rd_idx), .o_start_x(o_start_x), .o_start_y(o_start_y),
        .o_end_x(o_end_x), .o_end_y(o_end_y), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_box_cnt(o_box_cnt), .o_commit(o_commit), .o_err(o_err), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rec_t rand_rec(input bit ok);
        rec_t r;
        logic [10:0] tx;
        logic [9:0]  ty;
        r.sx = 11'($urandom); r.ex = 11'($urandom);
        r.sy = 10'($urandom); r.ey = 10'($urandom);
        r.r = 2'($urandom); r.g = 2'($urandom); r.b = 2'($urandom);
        if (r.sx > r.ex) begin tx = r.sx; r.sx = r.ex; r.ex = tx; end
        if (r.sy > r.ey) begin ty = r.sy; r.sy = r.ey; r.ey = ty; end
        if (!ok) begin
            if ($urandom % 2 == 0) begin
                r.ex = 11'($urandom_range(0, 1023));
                r.sx = r.ex + 11'($urandom_range(1, 1023));
            end else begin
                r.ey = 10'($urandom_range(0, 511));
                r.sy = r.ey + 10'($urandom_range(1, 511));
            end
        end
        return r;
    endfunction

    function automatic bit rec_valid(input rec_t r);
        return (r.sx <= r.ex) && (r.sy <= r.ey);
    endfunction

    task automatic send_pkt(input int extra, input bit vs_last);
        logic [7:0]  bytes[$];
        logic [47:0] w;
        rec_t        good[$];
        bit          exp_err;
        bit          exp_ovf;
        foreach (pkt[k]) begin
            w = pkt[k];
            for (int j = 0; j < 6; j++) bytes.push_back(w[47-8*j -: 8]);
        end
        for (int j = 0; j < extra; j++) bytes.push_back(8'($urandom));
        for (int j = 0; j < bytes.size(); j++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = bytes[j];
            i_last  = (j == bytes.size() - 1);
            i_vsync = vs_last && i_last;
        end
        @(negedge clk);
        i_valid = 1'b0; i_last = 1'b0; i_vsync = 1'b0; i_data = 8'h00;
        m_pend = 1'b0;
        foreach (pkt[k]) if (rec_valid(pkt[k])) good.push_back(pkt[k]);
        exp_err = (extra % 6) != 0;
        exp_ovf = !exp_err && (good.size() > MAX_BOX);
        check("err_pulse", o_err, exp_err);
        check("ovf_pulse", o_ovf, exp_ovf);
        check("no_commit_in_pkt", o_commit, 0);
        if (!exp_err) begin
            while (good.size() > MAX_BOX) void'(good.pop_back());
            m_shadow = good;
            m_pend = 1'b1;
        end
        @(negedge clk);
        check("err_one_cycle", o_err, 0);
        check("cnt_before_vsync", o_box_cnt, m_active.size());
    endtask

    task automatic vsync();
        @(negedge clk);
        i_vsync = 1'b1;
        @(negedge clk);
        i_vsync = 1'b0;
        check("commit_pulse", o_commit, m_pend);
        if (m_pend) begin
            m_active = m_shadow;
            m_pend = 1'b0;
        end
        check("box_cnt", o_box_cnt, m_active.size());
        @(negedge clk);
        check("commit_one_cycle", o_commit, 0);
    endtask

    task automatic check_table();
        foreach (m_active[i]) begin
            @(negedge clk);
            i_rd_idx = 3'(i);
            @(negedge clk);
            check("start_x", o_start_x, m_active[i].sx);
            check("start_y", o_start_y, m_active[i].sy);
            check("end_x", o_end_x, m_active[i].ex);
            check("end_y", o_end_y, m_active[i].ey);
            check("r", o_r, m_active[i].r * 8'h55);
            check("g", o_g, m_active[i].g * 8'h55);
            check("b", o_b, m_active[i].b * 8'h55);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_start_x", o_start_x, 0);
        check("rst_start_y", o_start_y, 0);
        check("rst_end_x", o_end_x, 0);
        check("rst_end_y", o_end_y, 0);
        check("rst_rgb", {o_r, o_g, o_b}, 0);
        check("rst_box_cnt", o_box_cnt, 0);
        check("rst_pulses", {o_commit, o_err, o_ovf}, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rstn = 1'b1;

        // Directed single box, committed only after vsync.
        pkt = {rec_t'(48'h00A00A0500C8)};
        send_pkt(0, 0);
        vsync();
        check_table();
        pkt = {rec_t'(48'h00A00A0500F9)};
        send_pkt(0, 0);
        vsync();
        check_table();

        pkt = {rand_rec(1), rand_rec(1), rand_rec(1)};
        send_pkt(0, 0);
        vsync();
        check_table();

        // Partial record at end: dropped, old table survives.
        pkt = {rand_rec(1)};
        send_pkt(2, 0);
        vsync();
        check_table();

        pkt = {};
        for (int k = 0; k < MAX_BOX + 2; k++) pkt.push_back(rand_rec(1));
        send_pkt(0, 0);
        vsync();
        check_table();

        pkt = {rand_rec(1), rand_rec(0), rand_rec(1)};
        pkt[1].sx = 11'd100;
        pkt[1].ex = 11'd50;
        send_pkt(0, 0);
        vsync();
        check_table();

        // vsync on the last byte defers the commit by one frame.
        pkt = {rand_rec(1), rand_rec(1)};
        send_pkt(0, 1);
        vsync();
        check_table();

        pkt = {rand_rec(0)};
        send_pkt(0, 0);
        vsync();

        pkt = {rand_rec(1)};
        send_pkt(0, 0);
        pkt = {rand_rec(1), rand_rec(1), rand_rec(1), rand_rec(1)};
        send_pkt(0, 0);
        vsync();
        check_table();

        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(1, 10);
            pkt = {};
            for (int k = 0; k < n; k++) pkt.push_back(rand_rec($urandom % 4 != 0));
            send_pkt(($urandom % 4 == 0) ? $urandom_range(1, 5) : 0, $urandom % 5 == 0);
            if ($urandom % 2 == 0) begin
                vsync();
                check_table();
            end
        end

        // Reset in the middle of a packet.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data = 8'($urandom);
        end
        @(negedge clk);
        i_valid = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        m_active = {};
        m_shadow = {};
        m_pend = 1'b0;
        rstn = 1'b1;
        vsync();
        pkt = {rand_rec(1), rand_rec(1)};
        send_pkt(0, 0);
        vsync();
        check_table();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
